// File: rtl/day3_edge_detector.sv
// ---------------------------------------------------------------------------
// day3_edge_detector
//
// Purpose:
//   Per-bit rising/falling edge detector for a level input sampled on clk.
//   The previous sample of every channel is held in a register.  It is
//   compared combinationally with the live input to produce one-cycle edge
//   pulses.  Each channel is fully independent of the others.
//
// Parameters:
//   WIDTH  - number of independent input channels
//   CNT_W  - width of each per-channel edge counter (counter build only)
//
// Ports:
//   clk             - rising-edge clock for all state
//   reset           - asynchronous active-high reset, released synchronously
//   a_i             - level input, already synchronous to clk
//   rising_edge_o   - bit n high while a_i[n]=1 and the previous sample was 0
//   falling_edge_o  - bit n high while a_i[n]=0 and the previous sample was 1
//   rise_cnt_o      - saturating count of rising pulses, CNT_W bits per
//                     channel, channel n at [n*CNT_W +: CNT_W]
//   fall_cnt_o      - saturating count of falling pulses, same layout
//
// Configuration:
//   DAY3_EDGE_COUNT_EN - when defined, adds rise_cnt_o/fall_cnt_o and the
//                        per-channel saturating counters behind them.
// ---------------------------------------------------------------------------
module day3_edge_detector #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       a_i,
  output logic [WIDTH-1:0]       rising_edge_o,
`ifdef DAY3_EDGE_COUNT_EN
  output logic [WIDTH-1:0]       falling_edge_o,
  output logic [WIDTH*CNT_W-1:0] rise_cnt_o,
  output logic [WIDTH*CNT_W-1:0] fall_cnt_o
`else
  output logic [WIDTH-1:0]       falling_edge_o
`endif
);

  logic [WIDTH-1:0] a_q;

  // Previous-sample register.  Reset clears it, so the first cycle after
  // reset treats the input as having been low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
    end else begin
      a_q <= a_i;
    end
  end

  // Edge decode.  Reset gates the outputs because a_q alone being zero
  // would otherwise let a high input show as a rising edge during reset.
  always_comb begin
    rising_edge_o  = '0;
    falling_edge_o = '0;
    if (!reset) begin
      rising_edge_o  = a_i & ~a_q;
      falling_edge_o = ~a_i & a_q;
    end
  end

`ifdef DAY3_EDGE_COUNT_EN
  // One pair of saturating counters per channel.  A counter that has
  // reached all-ones holds there instead of wrapping back to zero.
  for (genvar n = 0; n < WIDTH; n++) begin : g_cnt
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rise_cnt <= '0;
        fall_cnt <= '0;
      end else begin
        if (rising_edge_o[n] && (rise_cnt != {CNT_W{1'b1}})) begin
          rise_cnt <= rise_cnt + CNT_W'(1);
        end
        if (falling_edge_o[n] && (fall_cnt != {CNT_W{1'b1}})) begin
          fall_cnt <= fall_cnt + CNT_W'(1);
        end
      end
    end

    assign rise_cnt_o[n*CNT_W +: CNT_W] = rise_cnt;
    assign fall_cnt_o[n*CNT_W +: CNT_W] = fall_cnt;
  end
`endif

endmodule

// File: tb/tb_day3_edge_detector.sv
// ---------------------------------------------------------------------------
// tb_day3_edge_detector
//
// Self-checking bench for day3_edge_detector with WIDTH=4, CNT_W=2.
// Expected edge pulses are pushed to a queue as each input vector is driven.
// They are popped and compared once the combinational outputs have settled.
// The counter section is built only when DAY3_EDGE_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_day3_edge_detector;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] exp_f;
    string            name;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] f;
    string            name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] rising_edge_o;
  logic [WIDTH-1:0] falling_edge_o;
`ifdef DAY3_EDGE_COUNT_EN
  logic [WIDTH*CNT_W-1:0] rise_cnt_o;
  logic [WIDTH*CNT_W-1:0] fall_cnt_o;
`endif

  int vec_count;
  int miscompares;

  exp_t             exp_q[$];
  vec_t             table_q[$];
  logic [WIDTH-1:0] model_prev;

  day3_edge_detector #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .rising_edge_o  (rising_edge_o),
`ifdef DAY3_EDGE_COUNT_EN
    .falling_edge_o (falling_edge_o),
    .rise_cnt_o     (rise_cnt_o),
    .fall_cnt_o     (fall_cnt_o)
`else
    .falling_edge_o (falling_edge_o)
`endif
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check_output();
    exp_t e;
    vec_count++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (rising_edge_o !== e.r || falling_edge_o !== e.f) begin
        miscompares++;
        $display("[TB] FAIL %s: got rise=%b fall=%b, want rise=%b fall=%b",
                 e.name, rising_edge_o, falling_edge_o, e.r, e.f);
      end
    end
  endtask

  // Drive one vector after the falling edge, queue its expectation and
  // check it.  The reference previous sample then follows the value that
  // the next posedge will load into the DUT.
  task automatic apply_stimulus(input logic rst, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] er,
                                input logic [WIDTH-1:0] ef,
                                input string name);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst;
    a_i   = a;
    e.r = er;
    e.f = ef;
    e.name = name;
    exp_q.push_back(e);
    #1;
    check_output();
    model_prev = rst ? '0 : a;
  endtask

  // Same as apply_stimulus, with the expectation derived from the model.
  task automatic apply_model(input logic rst, input logic [WIDTH-1:0] a,
                             input string name);
    logic [WIDTH-1:0] er;
    logic [WIDTH-1:0] ef;
    er = rst ? '0 : (a & ~model_prev);
    ef = rst ? '0 : (~a & model_prev);
    apply_stimulus(rst, a, er, ef, name);
  endtask

  task automatic check_value(input string name, input logic [31:0] act,
                             input logic [31:0] want);
    vec_count++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  initial begin
    exp_t             e;
    logic [WIDTH-1:0] v;
    int               transitions;
    int               pulses;

    vec_count   = 0;
    miscompares = 0;
    model_prev  = '0;
    reset       = 1'b1;
    a_i         = '0;

    // Reset, single-channel sequences on bit 0, then multi-channel patterns.
    table_q.push_back('{1'b1, 4'h1, 4'h0, 4'h0, "rst_hold_a1_0"});
    table_q.push_back('{1'b1, 4'h1, 4'h0, 4'h0, "rst_hold_a1_1"});
    table_q.push_back('{1'b0, 4'h1, 4'h1, 4'h0, "rst_release_rise"});
    table_q.push_back('{1'b0, 4'h1, 4'h0, 4'h0, "after_release"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h1, "drop_to_0"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h0, "rise_seq_0"});
    table_q.push_back('{1'b0, 4'h1, 4'h1, 4'h0, "rise_seq_1"});
    table_q.push_back('{1'b0, 4'h1, 4'h0, 4'h0, "rise_seq_2"});
    table_q.push_back('{1'b0, 4'h1, 4'h0, 4'h0, "rise_seq_3"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h1, "fall_seq_1"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h0, "fall_seq_2"});
    table_q.push_back('{1'b0, 4'h1, 4'h1, 4'h0, "toggle_r0"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h1, "toggle_f0"});
    table_q.push_back('{1'b0, 4'h1, 4'h1, 4'h0, "toggle_r1"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'h1, "toggle_f1"});
    table_q.push_back('{1'b0, 4'hA, 4'hA, 4'h0, "multi_rise_A"});
    table_q.push_back('{1'b0, 4'h5, 4'h5, 4'hA, "multi_swap"});
    table_q.push_back('{1'b0, 4'hF, 4'hA, 4'h0, "multi_fill"});
    table_q.push_back('{1'b0, 4'h0, 4'h0, 4'hF, "multi_all_fall"});

    for (int i = 0; i < table_q.size(); i++) begin
      apply_stimulus(table_q[i].rst, table_q[i].a, table_q[i].exp_r,
                     table_q[i].exp_f, table_q[i].name);
    end

    // Random stimulus: model tracks the previous sample; total pulses seen
    // on the DUT must equal the number of bit transitions driven.
    transitions = 0;
    pulses      = 0;
    for (int i = 0; i < 32; i++) begin
      v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      transitions += $countones(v ^ model_prev);
      apply_model(1'b0, v, "random");
      pulses += $countones(rising_edge_o) + $countones(falling_edge_o);
    end
    check_value("pulse_vs_transition_count", pulses, transitions);

    // Mid-run reset: a rising pulse is live, reset between edges kills it
    // at once, and the lost history gives a fresh rising pulse afterwards.
    apply_model(1'b0, 4'hF, "midrst_setup_hi");
    apply_model(1'b0, 4'h0, "midrst_setup_lo");
    @(negedge clk);
    #1;
    a_i = 4'hF;
    e.r = 4'hF; e.f = 4'h0; e.name = "midrst_pulse_live";
    exp_q.push_back(e);
    #1;
    check_output();
    #1;
    reset = 1'b1;
    e.r = 4'h0; e.f = 4'h0; e.name = "midrst_async_drop";
    exp_q.push_back(e);
    #1;
    check_output();
    model_prev = '0;
    apply_stimulus(1'b1, 4'hF, 4'h0, 4'h0, "midrst_held");
    apply_stimulus(1'b0, 4'hF, 4'hF, 4'h0, "midrst_release_rise");
    apply_stimulus(1'b0, 4'hF, 4'h0, 4'h0, "midrst_steady");

`ifdef DAY3_EDGE_COUNT_EN
    // Counters: clear, then 5 rises and 5 falls on every channel; CNT_W=2
    // saturates each at 3.  A final reset must clear them asynchronously.
    apply_model(1'b1, 4'h0, "cnt_clear");
    check_value("rise_cnt_cleared", 32'(rise_cnt_o), 32'h0);
    apply_model(1'b0, 4'h0, "cnt_base");
    for (int i = 0; i < 5; i++) begin
      apply_model(1'b0, 4'hF, "cnt_rise");
      apply_model(1'b0, 4'h0, "cnt_fall");
    end
    @(posedge clk);
    #1;
    check_value("rise_cnt_saturated", 32'(rise_cnt_o), 32'hFF);
    check_value("fall_cnt_saturated", 32'(fall_cnt_o), 32'hFF);
    reset = 1'b1;
    #1;
    check_value("rise_cnt_after_reset", 32'(rise_cnt_o), 32'h0);
    check_value("fall_cnt_after_reset", 32'(fall_cnt_o), 32'h0);
    reset = 1'b0;
`endif

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: %0d expectations unchecked",
               exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count,
             miscompares);
    $finish;
  end

endmodule
